// File: rtl/id_ex_pkg.sv
// id_ex_pkg: shared constants, instruction field positions, FSM state codes,
// the ID/EX payload struct and small decode helpers for the decode/issue stage.
package id_ex_pkg;

  localparam int DATA_W   = 26;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 13;
  localparam int INSTR_W  = 32;
  localparam int IMM_W    = 13;

  // Instruction field bit positions
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 28;
  localparam int RD_HI  = 27;
  localparam int RD_LO  = 23;
  localparam int RS1_HI = 22;
  localparam int RS1_LO = 18;
  localparam int RS2_HI = 17;
  localparam int RS2_LO = 13;
  localparam int IMM_HI = 12;
  localparam int IMM_LO = 0;

  // Stage FSM state codes
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  // Contents of the ID/EX pipeline register
  typedef struct packed {
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] imm;
    logic              illegal;
  } idex_payload_t;

  // True when the index names an architectural register
  function automatic logic reg_ok(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // r0 and out-of-range indices read as zero; otherwise bypass or register file
  function automatic logic [DATA_W-1:0] select_operand(
    input logic [ADDR_W-1:0] rs,
    input logic              fwd,
    input logic [DATA_W-1:0] rf_data,
    input logic [DATA_W-1:0] wb_data
  );
    if (rs == '0 || !reg_ok(rs)) return '0;
    return fwd ? wb_data : rf_data;
  endfunction

  function automatic logic [DATA_W-1:0] sign_extend_imm(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: combinational load-use / writeback hazard detection.
// Build option ID_EX_FORWARD_EN: writeback matches become bypass selects
// instead of stalls.
module id_hazard_unit
  import id_ex_pkg::*;
(
  input  logic [ADDR_W-1:0] i_rs1,
  input  logic [ADDR_W-1:0] i_rs2,
  input  logic              i_ex_is_load,
  input  logic [ADDR_W-1:0] i_ex_rd,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  output logic              o_stall,
  output logic              o_fwd1,
  output logic              o_fwd2
);

  logic w_load_use;
  logic w_wb_hit1;
  logic w_wb_hit2;

  // A load in EX cannot supply its result in time; r0 is never a real dependency
  assign w_load_use = i_ex_is_load && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_rs1) || (i_ex_rd == i_rs2));

  assign w_wb_hit1 = i_wb_we && (i_wb_addr != '0) && (i_wb_addr == i_rs1);
  assign w_wb_hit2 = i_wb_we && (i_wb_addr != '0) && (i_wb_addr == i_rs2);

`ifdef ID_EX_FORWARD_EN
  // Write-through bypass: the writeback value is steered into the operand
  assign o_stall = w_load_use;
  assign o_fwd1  = w_wb_hit1;
  assign o_fwd2  = w_wb_hit2;
`else
  // No bypass: wait one cycle and re-read the register file after the write
  assign o_stall = w_load_use || w_wb_hit1 || w_wb_hit2;
  assign o_fwd1  = 1'b0;
  assign o_fwd2  = 1'b0;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode/issue stage in front of the 13 x 26-bit register file.
// Drives read addresses, samples read data on acceptance, detects hazards
// and holds the ID/EX pipeline register. Build option: ID_EX_FORWARD_EN.
module id_ex_stage
  import id_ex_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic [ADDR_W-1:0]  rf_a1,
  output logic [ADDR_W-1:0]  rf_a2,
  input  logic [DATA_W-1:0]  rf_rd1,
  input  logic [DATA_W-1:0]  rf_rd2,
  input  logic               wb_we,
  input  logic [ADDR_W-1:0]  wb_addr,
  input  logic [DATA_W-1:0]  wb_data,
  input  logic               ex_is_load,
  input  logic [ADDR_W-1:0]  ex_rd,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [3:0]         out_opcode,
  output logic [ADDR_W-1:0]  out_rd,
  output logic [DATA_W-1:0]  out_op1,
  output logic [DATA_W-1:0]  out_op2,
  output logic [DATA_W-1:0]  out_imm,
  output logic               out_illegal,
  output logic [15:0]        stall_cnt
);

  logic [3:0]        w_opcode;
  logic [ADDR_W-1:0] w_rd;
  logic [ADDR_W-1:0] w_rs1;
  logic [ADDR_W-1:0] w_rs2;
  logic [IMM_W-1:0]  w_imm13;
  logic              w_hazard;
  logic              w_fwd1;
  logic              w_fwd2;
  logic              w_accept;
  logic              w_stall_cycle;
  idex_payload_t     w_pl;

  logic [0:0]        r_state;
  logic              r_valid;
  idex_payload_t     r_pl;
  logic [15:0]       r_stall_cnt;

  assign w_opcode = in_instr[OPC_HI:OPC_LO];
  assign w_rd     = in_instr[RD_HI:RD_LO];
  assign w_rs1    = in_instr[RS1_HI:RS1_LO];
  assign w_rs2    = in_instr[RS2_HI:RS2_LO];
  assign w_imm13  = in_instr[IMM_HI:IMM_LO];

  assign rf_a1 = w_rs1;
  assign rf_a2 = w_rs2;

  id_hazard_unit u_hazard (
    .i_rs1        (w_rs1),
    .i_rs2        (w_rs2),
    .i_ex_is_load (ex_is_load),
    .i_ex_rd      (ex_rd),
    .i_wb_we      (wb_we),
    .i_wb_addr    (wb_addr),
    .o_stall      (w_hazard),
    .o_fwd1       (w_fwd1),
    .o_fwd2       (w_fwd2)
  );

  // Flush and reset block acceptance outright; otherwise accept when no hazard
  // and the ID/EX register is empty or being drained this cycle.
  assign in_ready = !rst && !flush && !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // A waiting instruction stays stalled until its hazard clears
  assign w_stall_cycle = w_hazard && !flush && (in_valid || (r_state == ST_STALL));

  // Build the payload the ID/EX register captures on acceptance
  always_comb begin
    // NOTE: default the whole struct first so no field can infer a latch.
    w_pl         = '0;
    w_pl.opcode  = w_opcode;
    w_pl.rd      = w_rd;
    w_pl.op1     = select_operand(w_rs1, w_fwd1, rf_rd1, wb_data);
    w_pl.op2     = select_operand(w_rs2, w_fwd2, rf_rd2, wb_data);
    w_pl.imm     = sign_extend_imm(w_imm13);
    w_pl.illegal = !reg_ok(w_rd) || !reg_ok(w_rs1) || !reg_ok(w_rs2);
  end

  // Stage FSM, ID/EX register and saturating bubble counter
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= ST_RUN;
      r_valid     <= 1'b0;
      // NOTE: payload is reset too, since every output must read 0 out of reset.
      r_pl        <= '0;
      r_stall_cnt <= '0;
    end else if (flush) begin
      r_state <= ST_RUN;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_stall_cycle ? ST_STALL : ST_RUN;
      if (w_stall_cycle && (r_stall_cnt != 16'hFFFF)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_accept) begin
        r_valid <= 1'b1;
        r_pl    <= w_pl;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = r_valid;
  assign out_opcode  = r_pl.opcode;
  assign out_rd      = r_pl.rd;
  assign out_op1     = r_pl.op1;
  assign out_op2     = r_pl.op2;
  assign out_imm     = r_pl.imm;
  assign out_illegal = r_pl.illegal;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenarios plus randomized traffic, checked every
// cycle against a behavioural model of the stage. Honours ID_EX_FORWARD_EN.
module tb_id_ex_stage;

  localparam int NR = 13;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rf_a1, rf_a2, wb_addr, ex_rd, out_rd;
  logic [25:0] rf_rd1, rf_rd2, wb_data, out_op1, out_op2, out_imm;
  logic        wb_we, ex_is_load, flush, out_valid, out_ready, out_illegal;
  logic [3:0]  out_opcode;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_ready(in_ready), .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_rd1(rf_rd1),
    .rf_rd2(rf_rd2), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_illegal(out_illegal), .stall_cnt(stall_cnt)
  );

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit        m_valid = 0, m_ill = 0, m_acc = 0;
  bit [3:0]  m_opcode = 0;
  bit [4:0]  m_rd = 0;
  bit [25:0] m_op1 = 0, m_op2 = 0, m_imm = 0;
  int        m_cnt = 0;

  function automatic bit f_hazard();
    logic [4:0] rs1, rs2;
    bit lu, wbh;
    rs1 = in_instr[22:18];
    rs2 = in_instr[17:13];
    lu  = ex_is_load && ex_rd != 0 && (ex_rd == rs1 || ex_rd == rs2);
    wbh = wb_we && wb_addr != 0 && (wb_addr == rs1 || wb_addr == rs2);
`ifdef ID_EX_FORWARD_EN
    return lu;
`else
    return lu || wbh;
`endif
  endfunction

  function automatic bit f_ready();
    return !rst && !flush && !f_hazard() && (!m_valid || out_ready);
  endfunction

  function automatic logic [25:0] f_operand(input logic [4:0] rs, input logic [25:0] rfd);
    if (rs == 0 || int'(rs) >= NR) return '0;
`ifdef ID_EX_FORWARD_EN
    if (wb_we && wb_addr == rs) return wb_data;
`endif
    return rfd;
  endfunction

  function automatic logic [25:0] f_sext(input logic [12:0] v);
    int x;
    x = int'(v);
    if (x >= 4096) x = x - 8192;
    return x[25:0];
  endfunction

  function automatic bit f_illegal(input logic [31:0] ins);
    return int'(ins[27:23]) >= NR || int'(ins[22:18]) >= NR || int'(ins[17:13]) >= NR;
  endfunction

  always @(posedge clk) begin
    m_acc <= in_valid && f_ready();
    if (rst) begin
      m_valid <= 0;
      m_cnt   <= 0;
    end else if (flush) begin
      m_valid <= 0;
    end else begin
      if (in_valid && f_hazard() && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (in_valid && f_ready()) begin
        m_valid  <= 1;
        m_opcode <= in_instr[31:28];
        m_rd     <= in_instr[27:23];
        m_op1    <= f_operand(in_instr[22:18], rf_rd1);
        m_op2    <= f_operand(in_instr[17:13], rf_rd2);
        m_imm    <= f_sext(in_instr[12:0]);
        m_ill    <= f_illegal(in_instr);
      end else if (out_ready) begin
        m_valid <= 0;
      end
    end
  end

  // Compare DUT against the model away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_in_ready",  in_ready,  f_ready());
      check("m_out_valid", out_valid, m_valid);
      check("m_stall_cnt", stall_cnt, m_cnt[15:0]);
      check("m_rf_a1",     rf_a1,     in_instr[22:18]);
      check("m_rf_a2",     rf_a2,     in_instr[17:13]);
      if (m_valid) begin
        check("m_opcode",  out_opcode,  m_opcode);
        check("m_rd",      out_rd,      m_rd);
        check("m_op1",     out_op1,     m_op1);
        check("m_op2",     out_op2,     m_op2);
        check("m_imm",     out_imm,     m_imm);
        check("m_illegal", out_illegal, m_ill);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [12:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  function automatic logic [4:0] rand_reg();
    if ($urandom_range(0, 7) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 15));
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  bit pend = 0;

  initial begin
    rst = 1; in_valid = 0; in_instr = '0; rf_rd1 = '0; rf_rd2 = '0;
    wb_we = 0; wb_addr = '0; wb_data = '0; ex_is_load = 0; ex_rd = '0;
    flush = 0; out_ready = 1;
    step();
    step();
    check("rst_valid", out_valid, 0);
    check("rst_cnt",   stall_cnt, 0);
    check("rst_op1",   out_op1,   0);
    check("rst_ill",   out_illegal, 0);
    rst = 0;
    cmp_en = 1;

    // Plain issue
    in_instr = mk(4'd5, 5'd2, 5'd3, 5'd4, 13'h1FFF);
    rf_rd1 = 26'h0000123; rf_rd2 = 26'h3FFFFFF; in_valid = 1;
    #1 check("plain_ready", in_ready, 1);
    step();
    in_valid = 0;
    check("plain_valid", out_valid, 1);
    check("plain_op1",   out_op1,   26'h0000123);
    check("plain_op2",   out_op2,   26'h3FFFFFF);
    check("plain_imm",   out_imm,   26'h3FFFFFF);
    check("plain_opc",   out_opcode, 5);
    check("plain_ill",   out_illegal, 0);

    // Load-use hazard: one bubble then issue
    in_instr = mk(4'd1, 5'd5, 5'd3, 5'd6, 13'h0010);
    rf_rd1 = 26'h0000777; ex_is_load = 1; ex_rd = 5'd3; in_valid = 1;
    #1 check("lu_ready_low", in_ready, 0);
    step();
    ex_is_load = 0;
    #1;
    check("lu_bubble", out_valid, 0);
    check("lu_cnt",    stall_cnt, 1);
    check("lu_ready",  in_ready,  1);
    step();
    in_valid = 0;
    check("lu_issue", out_valid, 1);
    check("lu_op1",   out_op1,   26'h0000777);
    check("lu_imm",   out_imm,   26'h0000010);

    // Writeback collision on rs2
    in_instr = mk(4'd2, 5'd7, 5'd0, 5'd4, 13'h0000);
    rf_rd1 = 26'h0000123; rf_rd2 = 26'h0;
    wb_we = 1; wb_addr = 5'd4; wb_data = 26'h0AAAAAA; in_valid = 1;
`ifdef ID_EX_FORWARD_EN
    #1 check("wb_ready", in_ready, 1);
    step();
    wb_we = 0; in_valid = 0;
    check("wb_cnt", stall_cnt, 1);
`else
    #1 check("wb_ready_low", in_ready, 0);
    step();
    wb_we = 0; rf_rd2 = 26'h0AAAAAA;
    #1 check("wb_ready", in_ready, 1);
    step();
    in_valid = 0;
    check("wb_cnt", stall_cnt, 2);
`endif
    check("wb_op2", out_op2, 26'h0AAAAAA);
    check("wb_op1_r0", out_op1, 0);

    // Backpressure then flush
    step();
    in_instr = mk(4'd3, 5'd8, 5'd9, 5'd10, 13'h0ABC);
    rf_rd1 = 26'h1111111; rf_rd2 = 26'h2222222; in_valid = 1;
    step();
    in_instr = mk(4'd4, 5'd1, 5'd1, 5'd1, 13'h0001);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check("bp_ready", in_ready, 0);
      step();
      check("bp_valid", out_valid, 1);
      check("bp_op1",   out_op1,   26'h1111111);
      check("bp_op2",   out_op2,   26'h2222222);
      check("bp_opc",   out_opcode, 3);
      check("bp_imm",   out_imm,   26'h0000ABC);
    end
    flush = 1;
    #1 check("fl_ready", in_ready, 0);
    step();
    flush = 0; in_valid = 0; out_ready = 1;
    check("fl_valid", out_valid, 0);
    step();
    check("fl_noaccept", out_valid, 0);

    // Illegal index and r0
    in_instr = mk(4'd6, 5'd1, 5'd13, 5'd0, 13'h1000);
    rf_rd1 = 26'h3000001; rf_rd2 = 26'h0000155; in_valid = 1;
    step();
    in_valid = 0;
    check("ill_valid", out_valid, 1);
    check("ill_flag",  out_illegal, 1);
    check("ill_op1",   out_op1, 0);
    check("ill_op2",   out_op2, 0);
    check("ill_imm",   out_imm, 26'h3FFF000);

    // Reset mid-stream with a held entry
    in_instr = mk(4'd7, 5'd2, 5'd2, 5'd2, 13'h0);
    in_valid = 1; out_ready = 0;
    step();
    in_valid = 0;
    check("mr_valid_pre", out_valid, 1);
    rst = 1;
    step();
    rst = 0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_cnt",   stall_cnt, 0);
    check("mr_ready", in_ready,  1);

    // Randomized traffic obeying valid/ready (instruction held until accepted)
    for (int c = 0; c < 3000; c++) begin
      if (m_acc) pend = 0;
      if (!pend && $urandom_range(0, 9) < 7) begin
        pend = 1;
        in_instr = mk(4'($urandom), rand_reg(), rand_reg(), rand_reg(), 13'($urandom));
      end
      in_valid   = pend;
      rf_rd1     = 26'($urandom);
      rf_rd2     = 26'($urandom);
      ex_is_load = ($urandom_range(0, 4) == 0);
      ex_rd      = 5'($urandom_range(0, 15));
      wb_we      = ($urandom_range(0, 9) < 3);
      wb_addr    = 5'($urandom_range(0, 15));
      wb_data    = 26'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 29) == 0);
      rst        = ($urandom_range(0, 199) == 0);
      step();
    end
    in_valid = 0; flush = 0; rst = 0; out_ready = 1;
    step();
    step();
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode/issue stage directly upstream of the 13-entry x 26-bit register file.
- Accepts a 32-bit instruction with valid/ready, drives the register-file read addresses, and samples the read data the same cycle.
- Detects load-use and pending-writeback hazards and registers the operands into the ID/EX pipeline register for the execute stage.

Parameters:
- DATA_W, 26, register/operand width.
- ADDR_W, 5, register address width.
- NUM_REGS, 13, number of architectural registers (valid indices 0..NUM_REGS-1).
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  instruction valid.
- in_instr  in  INSTR_W  [31:28] opcode, [27:23] rd, [22:18] rs1, [17:13] rs2, [12:0] imm13.
- in_ready  out  1  stage can accept instruction this cycle.
- rf_a1  out  ADDR_W  register-file read address 1 (= rs1).
- rf_a2  out  ADDR_W  register-file read address 2 (= rs2).
- rf_rd1  in  DATA_W  register-file read data 1.
- rf_rd2  in  DATA_W  register-file read data 2.
- wb_we  in  1  writeback write enable (same as register-file write enable).
- wb_addr  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback data.
- ex_is_load  in  1  instruction currently in EX is a load.
- ex_rd  in  ADDR_W  destination of instruction in EX.
- flush  in  1  kill the stage contents (branch redirect).
- out_valid  out  1  ID/EX register holds a valid instruction.
- out_ready  in  1  execute stage accepts.
- out_opcode  out  4  registered opcode.
- out_rd  out  ADDR_W  registered destination.
- out_op1  out  DATA_W  registered operand 1.
- out_op2  out  DATA_W  registered operand 2.
- out_imm  out  DATA_W  imm13 sign-extended to DATA_W.
- out_illegal  out  1  a register index in the instruction was >= NUM_REGS.
- stall_cnt  out  16  count of hazard bubble cycles, saturating.

Behaviour:
- Reset (sync, rst=1 at posedge): all outputs 0, state=RUN, stall_cnt=0. rst dominates flush and all handshakes.
- rf_a1/rf_a2 are combinational from in_instr; read data is sampled in the cycle the instruction is accepted.
- The ID/EX register loads when in_valid && in_ready. Latency is 1 cycle from acceptance to out_valid.
- in_ready = !hazard && (!out_valid || out_ready).
- Load-use hazard: ex_is_load && ex_rd != 0 && (ex_rd==rs1 || ex_rd==rs2).
- Writeback hazard (FORWARD_EN undefined only): wb_we && wb_addr != 0 && (wb_addr==rs1 || wb_addr==rs2).
- FSM states:
  - RUN: on hazard with in_valid → STALL; otherwise accept normally.
  - STALL: in_ready=0. If downstream takes the held entry (out_ready), out_valid is cleared, giving a bubble. stall_cnt increments every STALL cycle and saturates at 0xFFFF. Returns to RUN when the hazard clears.
- Register 0 reads as 0 regardless of rf_rd data. Writes/hazards on address 0 are ignored.
- out_illegal=1 if rd, rs1 or rs2 >= NUM_REGS; the corresponding operand is 0. The instruction still issues with out_valid=1.
- Backpressure: while out_valid && !out_ready, all out_* hold stable.
- Flush: next posedge out_valid=0, state=RUN; in_ready is forced 0 in the flush cycle so no instruction is accepted. Flush during STALL discards the stall.
- Simultaneous load-use hazard and writeback match: load-use wins (stall).

Optional Feature:
- Macro: ID_EX_FORWARD_EN.
- Defined: when wb_we && wb_addr==rsN && wb_addr!=0, opN takes wb_data instead of rf_rdN (write-through bypass). No writeback stall.
- Undefined: such a match is a hazard, giving a 1-cycle STALL; the operand is re-read after the write completes.

Decomposition:
- Package id_ex_pkg: DATA_W/ADDR_W/NUM_REGS constants, instruction field bit positions, state enum {RUN, STALL}, ID/EX payload struct (opcode, rd, op1, op2, imm, illegal).
- One sub-module: id_hazard_unit, a combinational block with inputs rs1, rs2, ex_is_load, ex_rd, wb_we, wb_addr and outputs stall and fwd1/fwd2.
- The FSM and pipeline register live in the top module.

Test Plan:
- Reset: drive rst=1 mid-stream with out_valid=1 → next cycle out_valid=0, stall_cnt=0, in_ready=1.
- Plain issue: instr rs1=3, rs2=4, rf_rd1=0x0000123, rf_rd2=0x3FFFFFF, imm13=0x1FFF → after 1 cycle out_op1=0x0000123, out_op2=0x3FFFFFF, out_imm=0x3FFFFFF.
- Load-use: ex_is_load=1, ex_rd=3, incoming rs1=3 → in_ready=0 for 1 cycle, one bubble (out_valid=0), stall_cnt=1, then the instruction issues.
- Writeback collision: wb_we=1, wb_addr=4, wb_data=0x0AAAAAA, rs2=4, rf_rd2=0 → with ID_EX_FORWARD_EN out_op2=0x0AAAAAA with no stall; without it 1 STALL cycle, then op2 comes from the register file.
- Backpressure + flush: out_ready=0 for 3 cycles → out_* stable; then flush=1 → out_valid=0 next cycle, no new instruction accepted that cycle.
- Illegal/r0: rs1=13 → out_illegal=1, out_op1=0; rs2=0 with rf_rd2=0x155 → out_op2=0.
